// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a shared UART_TX, with a frame watchdog and a run-time bit-period register.
// The grant is registered one cycle after DV is sampled, and requests get no Ack while a frame is in flight.
module uart_tx_arbiter #(
  parameter logic [11:0] CLKS_PER_BIT_DEFAULT = 12'hD05
) (
  input  logic        i_Clock,
  input  logic        i_Rst_H,
  input  logic        i_Req0_DV,
  input  logic [7:0]  i_Req0_Byte,
  output logic        o_Req0_Ack,
  input  logic        i_Req1_DV,
  input  logic [7:0]  i_Req1_Byte,
  output logic        o_Req1_Ack,
  input  logic        i_Cfg_WE,
  input  logic [11:0] i_Cfg_Clk_per_bit,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  output logic [11:0] o_Clk_per_bit,
  input  logic        i_TX_Done,
  output logic        o_Busy,
  output logic        o_Grant,
  output logic        o_Timeout
);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_tx_dv, w_tx_dv_nxt;
  logic [7:0]  r_tx_byte, w_tx_byte_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_grant, w_grant_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [11:0] r_cpb, w_cpb_nxt;
  logic        r_pend_vld, w_pend_vld_nxt;
  logic [11:0] r_pend_val, w_pend_val_nxt;
  logic [15:0] r_wdog, w_wdog_nxt;

  logic        w_cfg_ok;
  logic        w_any_req;
  logic        w_pick1;
  logic [15:0] w_wdog_limit;

  assign w_cfg_ok     = i_Cfg_WE && (i_Cfg_Clk_per_bit != 12'd0);
  assign w_any_req    = i_Req0_DV || i_Req1_DV;
  // With both requesting, the one that did not win last time goes next
  assign w_pick1      = i_Req1_DV && (!i_Req0_DV || !r_grant);
  assign w_wdog_limit = {4'b0000, r_cpb} * 16'd11;

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_dv_nxt    = 1'b0;
    w_tx_byte_nxt  = r_tx_byte;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_grant_nxt    = r_grant;
    w_timeout_nxt  = 1'b0;
    w_cpb_nxt      = r_cpb;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_val_nxt = r_pend_val;
    w_wdog_nxt     = r_wdog;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt   = WAIT_DONE;
          w_tx_dv_nxt   = 1'b1;
          w_tx_byte_nxt = w_pick1 ? i_Req1_Byte : i_Req0_Byte;
          w_ack0_nxt    = !w_pick1;
          w_ack1_nxt    = w_pick1;
          w_grant_nxt   = w_pick1;
          w_busy_nxt    = 1'b1;
          w_wdog_nxt    = 16'd0;
          if (w_cfg_ok) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_val_nxt = i_Cfg_Clk_per_bit;
          end
        end else if (w_cfg_ok) begin
          w_cpb_nxt = i_Cfg_Clk_per_bit;
        end
      end
      WAIT_DONE: begin
        if (w_cfg_ok) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_val_nxt = i_Cfg_Clk_per_bit;
        end
        if (i_TX_Done || (r_wdog == w_wdog_limit)) begin
          w_state_nxt    = IDLE;
          w_busy_nxt     = 1'b0;
          w_timeout_nxt  = !i_TX_Done;
          w_wdog_nxt     = 16'd0;
          w_pend_vld_nxt = 1'b0;
          // Newest write wins, so it lands in the first IDLE cycle ahead of any grant
          if (w_cfg_ok)
            w_cpb_nxt = i_Cfg_Clk_per_bit;
          else if (r_pend_vld)
            w_cpb_nxt = r_pend_val;
        end else begin
          w_wdog_nxt = r_wdog + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst_H) begin
      r_state    <= IDLE;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= 1'b1;
      r_timeout  <= 1'b0;
      r_cpb      <= CLKS_PER_BIT_DEFAULT;
      r_pend_vld <= 1'b0;
      r_pend_val <= 12'd0;
      r_wdog     <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_dv    <= w_tx_dv_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_busy     <= w_busy_nxt;
      r_grant    <= w_grant_nxt;
      r_timeout  <= w_timeout_nxt;
      r_cpb      <= w_cpb_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_wdog     <= w_wdog_nxt;
    end
  end

  assign o_TX_DV       = r_tx_dv;
  assign o_TX_Byte     = r_tx_byte;
  assign o_Req0_Ack    = r_ack0;
  assign o_Req1_Ack    = r_ack1;
  assign o_Busy        = r_busy;
  assign o_Grant       = r_grant;
  assign o_Timeout     = r_timeout;
  assign o_Clk_per_bit = r_cpb;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a scoreboard of expected {grant, byte} per frame, plus a UART_TX done-responder.
module tb_uart_tx_arbiter;

  logic        i_Clock;
  logic        i_Rst_H;
  logic        i_Req0_DV;
  logic [7:0]  i_Req0_Byte;
  logic        o_Req0_Ack;
  logic        i_Req1_DV;
  logic [7:0]  i_Req1_Byte;
  logic        o_Req1_Ack;
  logic        i_Cfg_WE;
  logic [11:0] i_Cfg_Clk_per_bit;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic [11:0] o_Clk_per_bit;
  logic        i_TX_Done;
  logic        o_Busy;
  logic        o_Grant;
  logic        o_Timeout;

  uart_tx_arbiter #(.CLKS_PER_BIT_DEFAULT(12'hD05)) dut (
    .i_Clock(i_Clock), .i_Rst_H(i_Rst_H),
    .i_Req0_DV(i_Req0_DV), .i_Req0_Byte(i_Req0_Byte), .o_Req0_Ack(o_Req0_Ack),
    .i_Req1_DV(i_Req1_DV), .i_Req1_Byte(i_Req1_Byte), .o_Req1_Ack(o_Req1_Ack),
    .i_Cfg_WE(i_Cfg_WE), .i_Cfg_Clk_per_bit(i_Cfg_Clk_per_bit),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_Clk_per_bit(o_Clk_per_bit),
    .i_TX_Done(i_TX_Done), .o_Busy(o_Busy), .o_Grant(o_Grant), .o_Timeout(o_Timeout)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb[$];
  logic [8:0] mon_exp;
  logic       auto_done;
  int         done_dly;
  logic       done_kick;

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 400) begin
      tick();
      n++;
    end
    check("idle_bound", {31'd0, o_Busy}, 0);
  endtask

  // Every frame start (or stray Ack) must match the oldest expected grant
  always @(negedge i_Clock) begin
    if (o_TX_DV || o_Req0_Ack || o_Req1_Ack) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {20'd0, o_TX_DV, o_Req1_Ack, o_Req0_Ack, o_Grant, o_TX_Byte}, 0);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_txdv", {31'd0, o_TX_DV}, 1);
        check("sb_grant", {31'd0, o_Grant}, {31'd0, mon_exp[8]});
        check("sb_byte", {24'd0, o_TX_Byte}, {24'd0, mon_exp[7:0]});
        check("sb_ack", {30'd0, o_Req1_Ack, o_Req0_Ack}, mon_exp[8] ? 32'd2 : 32'd1);
        check("sb_busy", {31'd0, o_Busy}, 1);
      end
    end
  end

  // UART_TX stand-in: done sampled when the watchdog count equals done_dly, or on demand
  initial begin
    int cnt;
    cnt = -1;
    i_TX_Done = 1'b0;
    forever begin
      @(posedge i_Clock);
      #2;
      if (o_TX_DV && auto_done) cnt = done_dly;
      i_TX_Done = done_kick;
      if (cnt == 0) begin
        i_TX_Done = 1'b1;
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  got0, got1;
    i_Rst_H = 1'b1;
    i_Req0_DV = 1'b0; i_Req0_Byte = 8'h00;
    i_Req1_DV = 1'b0; i_Req1_Byte = 8'h00;
    i_Cfg_WE = 1'b0; i_Cfg_Clk_per_bit = 12'd0;
    auto_done = 1'b1; done_dly = 3; done_kick = 1'b0;
    repeat (3) tick();
    check("rst_txdv", {31'd0, o_TX_DV}, 0);
    check("rst_byte", {24'd0, o_TX_Byte}, 0);
    check("rst_busy", {31'd0, o_Busy}, 0);
    check("rst_grant", {31'd0, o_Grant}, 1);
    check("rst_timeout", {31'd0, o_Timeout}, 0);
    check("rst_cpb", {20'd0, o_Clk_per_bit}, 32'hD05);
    check("rst_acks", {30'd0, o_Req1_Ack, o_Req0_Ack}, 0);
    i_Rst_H = 1'b0;
    tick();

    // Both requesting: req0 first after reset, and again on the second round
    for (int r = 0; r < 2; r++) begin
      i_Req0_DV = 1'b1; i_Req0_Byte = 8'hCD;
      i_Req1_DV = 1'b1; i_Req1_Byte = 8'h54;
      sb.push_back({1'b0, 8'hCD});
      sb.push_back({1'b1, 8'h54});
      got0 = 0; got1 = 0;
      for (int i = 0; i < 60 && !(got0 && got1); i++) begin
        tick();
        if (o_Req0_Ack) begin i_Req0_DV = 1'b0; got0 = 1; end
        if (o_Req1_Ack) begin i_Req1_DV = 1'b0; got1 = 1; end
      end
      check("rr_both_acked", {30'd0, got1, got0}, 3);
      wait_idle();
    end

    // Single request, one-cycle latency, byte held after the pulse
    i_Req0_DV = 1'b1; i_Req0_Byte = 8'hAF;
    sb.push_back({1'b0, 8'hAF});
    tick();
    check("r32_txdv", {31'd0, o_TX_DV}, 1);
    check("r32_ack0", {31'd0, o_Req0_Ack}, 1);
    check("r32_grant", {31'd0, o_Grant}, 0);
    check("r32_busy", {31'd0, o_Busy}, 1);
    i_Req0_DV = 1'b0;
    tick();
    check("r32_txdv_pulse", {31'd0, o_TX_DV}, 0);
    check("r32_ack_pulse", {31'd0, o_Req0_Ack}, 0);
    check("r32_byte_hold", {24'd0, o_TX_Byte}, 32'hAF);
    tick(); tick();
    check("r32_busy_wait", {31'd0, o_Busy}, 1);
    tick();
    check("r32_busy_done", {31'd0, o_Busy}, 0);
    check("r32_byte_idle", {24'd0, o_TX_Byte}, 32'hAF);

    // Writes during a frame are held pending; the last non-zero one is applied
    i_Req1_DV = 1'b1; i_Req1_Byte = 8'h3C;
    sb.push_back({1'b1, 8'h3C});
    tick();
    check("r34_ack1", {31'd0, o_Req1_Ack}, 1);
    i_Req1_DV = 1'b0;
    i_Cfg_WE = 1'b1; i_Cfg_Clk_per_bit = 12'h0FF;
    tick();
    i_Cfg_Clk_per_bit = 12'h01A;
    tick();
    i_Cfg_Clk_per_bit = 12'h000;
    tick();
    i_Cfg_WE = 1'b0;
    check("r34_cpb_hold", {20'd0, o_Clk_per_bit}, 32'hD05);
    tick();
    check("r34_idle", {31'd0, o_Busy}, 0);
    check("r34_cpb_idle", {20'd0, o_Clk_per_bit}, 32'h01A);

    // IDLE writes: immediate update, zero ignored
    i_Cfg_WE = 1'b1; i_Cfg_Clk_per_bit = 12'h010;
    tick();
    i_Cfg_WE = 1'b0;
    check("cfg_idle", {20'd0, o_Clk_per_bit}, 32'h010);
    i_Cfg_WE = 1'b1; i_Cfg_Clk_per_bit = 12'h000;
    tick();
    i_Cfg_WE = 1'b0;
    check("cfg_zero", {20'd0, o_Clk_per_bit}, 32'h010);

    // Watchdog: limit 11*16 = 176, plus a write that coincides with the grant
    auto_done = 1'b0;
    i_Req0_DV = 1'b1; i_Req0_Byte = 8'h5A;
    i_Cfg_WE = 1'b1; i_Cfg_Clk_per_bit = 12'h020;
    sb.push_back({1'b0, 8'h5A});
    tick();
    i_Req0_DV = 1'b0; i_Cfg_WE = 1'b0;
    check("r35_txdv", {31'd0, o_TX_DV}, 1);
    check("r28_cpb_grant", {20'd0, o_Clk_per_bit}, 32'h010);
    n = 0;
    while (!o_Timeout && n < 300) begin
      tick();
      n++;
    end
    check("r35_latency", n, 177);
    check("r35_busy", {31'd0, o_Busy}, 0);
    check("r28_cpb_applied", {20'd0, o_Clk_per_bit}, 32'h020);
    tick();
    check("r35_pulse", {31'd0, o_Timeout}, 0);
    i_Cfg_WE = 1'b1; i_Cfg_Clk_per_bit = 12'h010;
    tick();
    i_Cfg_WE = 1'b0;

    // Done arriving on the very cycle the watchdog reaches its limit
    auto_done = 1'b1; done_dly = 176;
    i_Req0_DV = 1'b1; i_Req0_Byte = 8'h6B;
    sb.push_back({1'b0, 8'h6B});
    tick();
    i_Req0_DV = 1'b0;
    n = 0;
    while (o_Busy && n < 300) begin
      tick();
      n++;
    end
    check("r37_latency", n, 177);
    check("r37_timeout", {31'd0, o_Timeout}, 0);

    // Reset in mid-frame, with req1 waiting
    auto_done = 1'b0; done_dly = 3;
    i_Req0_DV = 1'b1; i_Req0_Byte = 8'h77;
    sb.push_back({1'b0, 8'h77});
    tick();
    i_Req0_DV = 1'b0;
    tick(); tick();
    i_Req1_DV = 1'b1; i_Req1_Byte = 8'h99;
    tick();
    check("r36_no_ack_wait", {31'd0, o_Req1_Ack}, 0);
    i_Rst_H = 1'b1;
    tick();
    i_Rst_H = 1'b0;
    check("r36_txdv", {31'd0, o_TX_DV}, 0);
    check("r36_byte", {24'd0, o_TX_Byte}, 0);
    check("r36_busy", {31'd0, o_Busy}, 0);
    check("r36_grant", {31'd0, o_Grant}, 1);
    check("r36_timeout", {31'd0, o_Timeout}, 0);
    check("r36_cpb", {20'd0, o_Clk_per_bit}, 32'hD05);
    check("r36_acks", {30'd0, o_Req1_Ack, o_Req0_Ack}, 0);
    sb.push_back({1'b1, 8'h99});
    tick();
    check("r36_ack1", {31'd0, o_Req1_Ack}, 1);
    check("r36_grant1", {31'd0, o_Grant}, 1);
    i_Req1_DV = 1'b0;
    done_kick = 1'b1;
    tick();
    done_kick = 1'b0;
    tick();
    check("r36_done", {31'd0, o_Busy}, 0);
    check("r36_no_timeout", {31'd0, o_Timeout}, 0);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT_DEFAULT, default 12'hD05, the bit period in clocks loaded at reset (9600 baud at 32 MHz).
REQ-002 i_Clock  input  1  single clock; all logic rising-edge.
REQ-003 i_Rst_H  input  1  synchronous reset, active-high.
REQ-004 i_Req0_DV  input  1  requester 0 has a byte to send, level.
REQ-005 i_Req0_Byte  input  8  requester 0 data.
REQ-006 o_Req0_Ack  output  1  one-cycle pulse when requester 0 byte is captured.
REQ-007 i_Req1_DV, i_Req1_Byte, o_Req1_Ack SHALL mirror REQ-004..006 (1/8/1 bits) for requester 1.
REQ-008 i_Cfg_WE  input  1  one-cycle write strobe for the bit-period register.
REQ-009 i_Cfg_Clk_per_bit  input  12  new bit period.
REQ-010 o_TX_DV  output  1  start pulse to the shared UART_TX.
REQ-011 o_TX_Byte  output  8  byte to the UART_TX.
REQ-012 o_Clk_per_bit  output  12  bit period to the UART_TX.
REQ-013 i_TX_Done  input  1  UART_TX frame-complete pulse.
REQ-014 o_Busy  output  1  high while a frame is in flight.
REQ-015 o_Grant  output  1  index of the requester last granted.
REQ-016 o_Timeout  output  1  one-cycle pulse when a frame is aborted by the watchdog.

Function
REQ-017 FSM states SHALL be IDLE and WAIT_DONE; all outputs SHALL be registered.
REQ-018 IDLE, no DV asserted: stay in IDLE; o_TX_DV=0; o_Busy=0.
REQ-019 IDLE, a DV sampled high in cycle N: in cycle N+1, o_TX_DV=1 for exactly one cycle, o_TX_Byte=captured byte, the matching Ack=1 for one cycle, o_Grant=winner, o_Busy=1, state=WAIT_DONE.
REQ-020 Both DV high in IDLE: the requester not equal to o_Grant SHALL win (round-robin); after reset requester 0 wins first.
REQ-021 o_TX_Byte SHALL hold its value until the next grant.
REQ-022 Requesters SHALL drop DV in the cycle after Ack; DV still high in the first IDLE cycle is a new request.
REQ-023 WAIT_DONE: a DV SHALL be ignored (no Ack) until return to IDLE.
REQ-024 WAIT_DONE, i_TX_Done=1: next cycle state=IDLE, o_Busy=0; minimum one IDLE cycle between frames.
REQ-025 Watchdog: a 16-bit counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle; when it equals 11*o_Clk_per_bit (computed in 16 bits, max 45045), next cycle state=IDLE, o_Busy=0, o_Timeout=1 for one cycle.
REQ-026 i_TX_Done and the watchdog limit in the same cycle: treated as done; o_Timeout SHALL stay 0.
REQ-027 i_Cfg_WE in IDLE, with no DV high: o_Clk_per_bit updates next cycle.
REQ-028 i_Cfg_WE in WAIT_DONE, or in IDLE concurrent with a grant: value SHALL be stored as pending and applied on the first cycle back in IDLE, before any further grant; a later write SHALL overwrite pending.
REQ-029 i_Cfg_Clk_per_bit=0 SHALL be ignored (register and pending unchanged).

Reset
REQ-030 On i_Rst_H=1 at a clock edge: state=IDLE; o_TX_DV=0, o_TX_Byte=8'h00, both Acks=0, o_Busy=0, o_Timeout=0, o_Grant=1 (so requester 0 wins first), o_Clk_per_bit=CLKS_PER_BIT_DEFAULT, pending cleared, watchdog=0.
REQ-031 Reset during WAIT_DONE SHALL abort the frame with no Ack and no Timeout pulse; the UART_TX is reset by the same i_Rst_H.

Verification
REQ-032 Req0 DV with byte 8'hAF in IDLE -> one cycle later o_TX_DV=1, o_TX_Byte=8'hAF, o_Req0_Ack=1, o_Grant=0; Done pulse -> o_Busy=0 next cycle.
REQ-033 Both DV high together, bytes 8'hCD (req0) and 8'h54 (req1), held until Ack -> 8'hCD sent first, then 8'h54, o_Grant 0 then 1; repeat -> req0 wins again.
REQ-034 Cfg write 12'h01A during a frame -> o_Clk_per_bit stays 12'hD05 until Done, then 12'h01A in the first IDLE cycle before the next grant.
REQ-035 Grant with i_TX_Done held 0, o_Clk_per_bit=12'h010 -> o_Timeout pulse 177 cycles after o_TX_DV (176 WAIT_DONE counts + 1), then IDLE.
REQ-036 Reset asserted mid-frame -> next cycle all outputs at REQ-030 values, o_Clk_per_bit=12'hD05; a pending req1 DV afterwards gets Ack with o_Grant=1, because requester 0 is not requesting.
REQ-037 i_TX_Done coincident with the watchdog limit -> IDLE, o_Timeout=0; Cfg write of 12'h000 -> o_Clk_per_bit unchanged.
